// File: rtl/dpi_int_pkg.sv
// Shared request/delivery types, injection-queue FSM states and lane popcount helper.
package dpi_int_pkg;
  localparam int ADDR_W = 8;
  localparam int ID_W   = 16;
  localparam int SIZE_W = 8;
  localparam int MAX_NE = 64;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dest;
    logic [ID_W-1:0]   id;
    logic [SIZE_W-1:0] size;
  } req_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } deliver_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} inj_state_t;

  // Callers zero-extend their NE-wide lane vector to MAX_NE bits.
  function automatic logic [7:0] popcount_ne(input logic [MAX_NE-1:0] v);
    popcount_ne = '0;
    for (int i = 0; i < MAX_NE; i++) popcount_ne = popcount_ne + 8'(v[i]);
  endfunction
endpackage

// File: rtl/synfull_lane_fifo.sv
// Per-endpoint request FIFO; pointers carry one extra wrap bit to tell full from empty.
module synfull_lane_fifo import dpi_int_pkg::*; #(
  parameter int  DEPTH = 4,
  parameter type T     = req_t
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  T                         din_i,
  output T                         head_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  T           mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;

  assign wr_d = push_i ? wr_q + (AW+1)'(1) : wr_q;
  assign rd_d = pop_i  ? rd_q + (AW+1)'(1) : rd_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Payload storage needs no reset; only the pointers define occupancy.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  assign head_o  = mem_q[rd_q[AW-1:0]];
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o = wr_q - rd_q;
endmodule

// File: rtl/synfull_inj_queue.sv
// Hardware injection queues in front of the NoC injectors, with drop/in-flight accounting
// and a run/drain/done controller that reports when all traffic has retired.
module synfull_inj_queue import dpi_int_pkg::*; #(
  parameter int NE     = 4,
  parameter int DEPTH  = 4,
  parameter int BYPASS = 1,
  parameter int CNT_W  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 end_i,
  input  req_t     [NE-1:0]    req_in_i,
  output logic     [NE-1:0]    full_o,
  input  logic     [NE-1:0]    NE_ready_all_i,
  output req_t     [NE-1:0]    req_out_o,
  input  deliver_t [NE-1:0]    del_all_i,
  output logic     [CNT_W-1:0] inflight_o,
  output logic     [CNT_W-1:0] drop_cnt_o,
  output logic     [NE-1:0]    ovf_o,
  output logic                 err_o,
  output logic                 done_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CNT_W + 8;
  localparam logic [SW-1:0] SAT = {8'd0, {CNT_W{1'b1}}};

  inj_state_t state_q, state_d;
  logic                 run;
  logic [NE-1:0]        empty, lfull, push, pop, inj, drop, ovf_set, busy, del_v;
  req_t [NE-1:0]        head;
  logic [NE-1:0][CW-1:0] cnt;
  logic [NE-1:0][ID_W-1:0] del_id;

  assign run = (state_q == S_RUN);

  for (genvar k = 0; k < NE; k++) begin : g_lane
    logic byp_cand, byp, push_want, offer;
    assign byp_cand  = (BYPASS != 0) && empty[k] && req_in_i[k].valid && run;
    assign byp       = byp_cand && NE_ready_all_i[k];
    assign offer     = !empty[k] || byp_cand;
    assign inj[k]    = offer && NE_ready_all_i[k];
    assign pop[k]    = !empty[k] && NE_ready_all_i[k];
    // A not-ready bypass candidate falls through to a normal push.
    assign push_want = req_in_i[k].valid && run && !byp;
    assign push[k]   = push_want && (!lfull[k] || pop[k]);
    assign ovf_set[k] = push_want && lfull[k] && !pop[k];
    assign drop[k]   = (req_in_i[k].valid && !run) || ovf_set[k];
    assign busy[k]   = push[k] || pop[k] || (cnt[k] != '0);
    assign del_v[k]  = del_all_i[k].valid;
    assign del_id[k] = del_all_i[k].id;
    assign req_out_o[k] = !offer ? '0 : (empty[k] ? req_in_i[k] : head[k]);

    synfull_lane_fifo #(.DEPTH(DEPTH), .T(req_t)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push[k]),
      .pop_i   (pop[k]),
      .din_i   (req_in_i[k]),
      .head_o  (head[k]),
      .empty_o (empty[k]),
      .full_o  (lfull[k]),
      .count_o (cnt[k])
    );
  end

  logic unused_del_id;
  assign unused_del_id = ^del_id;

  logic [CNT_W-1:0] inflight_q, inflight_d, drop_q, drop_d;
  logic [NE-1:0]    ovf_q, ovf_d;
  logic             err_q, err_d, infl_under;
  logic [SW-1:0]    n_inj, n_del, n_drop, infl_sum, infl_diff, drop_sum;

  assign n_inj  = SW'(popcount_ne(MAX_NE'(inj)));
  assign n_del  = SW'(popcount_ne(MAX_NE'(del_v)));
  assign n_drop = SW'(popcount_ne(MAX_NE'(drop)));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_RUN;
      S_RUN:   if (end_i)   state_d = S_DRAIN;
      S_DRAIN: if (!(|busy) && inflight_q == '0) state_d = S_DONE;
      S_DONE:  if (start_i) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Injections and deliveries net out first; only the net result is clamped.
  always_comb begin
    infl_sum   = SW'(inflight_q) + n_inj;
    infl_diff  = infl_sum - n_del;
    infl_under = (infl_sum < n_del);
    if (infl_under)          inflight_d = '0;
    else if (infl_diff > SAT) inflight_d = '1;
    else                     inflight_d = CNT_W'(infl_diff);
    err_d    = err_q | infl_under;
    drop_sum = SW'(drop_q) + n_drop;
    drop_d   = (drop_sum > SAT) ? '1 : CNT_W'(drop_sum);
    ovf_d    = ovf_q | ovf_set;
    if (state_q == S_DONE && start_i) begin
      drop_d = '0;
      ovf_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      inflight_q <= '0;
      drop_q     <= '0;
      ovf_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
    end
  end

  assign full_o     = lfull;
  assign inflight_o = inflight_q;
  assign drop_cnt_o = drop_q;
  assign ovf_o      = ovf_q;
  assign err_o      = err_q;
  assign done_o     = (state_q == S_DONE);
endmodule

// File: tb/tb_synfull_inj_queue.sv
// Directed bench: a non-bypass instance (_a) and a bypass instance (_b) share all inputs.
module tb_synfull_inj_queue;
  import dpi_int_pkg::*;
  localparam int NE = 4, DEPTH = 4, CNT_W = 16;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, fin = 1'b0;
  req_t     [NE-1:0] req_in;
  logic     [NE-1:0] ready;
  deliver_t [NE-1:0] del;
  logic     [NE-1:0] full_a, full_b, ovf_a, ovf_b;
  req_t     [NE-1:0] out_a, out_b;
  logic [CNT_W-1:0]  infl_a, infl_b, drop_a, drop_b;
  logic              err_a, err_b, done_a, done_b;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  synfull_inj_queue #(.NE(NE), .DEPTH(DEPTH), .BYPASS(0), .CNT_W(CNT_W)) u_nb (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .end_i(fin), .req_in_i(req_in),
    .full_o(full_a), .NE_ready_all_i(ready), .req_out_o(out_a), .del_all_i(del),
    .inflight_o(infl_a), .drop_cnt_o(drop_a), .ovf_o(ovf_a), .err_o(err_a), .done_o(done_a));

  synfull_inj_queue #(.NE(NE), .DEPTH(DEPTH), .BYPASS(1), .CNT_W(CNT_W)) u_by (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .end_i(fin), .req_in_i(req_in),
    .full_o(full_b), .NE_ready_all_i(ready), .req_out_o(out_b), .del_all_i(del),
    .inflight_o(infl_b), .drop_cnt_o(drop_b), .ovf_o(ovf_b), .err_o(err_b), .done_o(done_b));

  function automatic req_t mk(input logic [15:0] id);
    mk = '0; mk.valid = 1'b1; mk.src = 8'd1; mk.dest = 8'd2; mk.id = id; mk.size = 8'd4;
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; fin = 1'b0; req_in = '0; ready = '0; del = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic start_run();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_in = '0; ready = '0; del = '0; #3;
    n_cmp++; if (out_a !== '0) begin n_bad++; $display("FAIL rst_out: got %0h want 0", out_a); end
    n_cmp++; if ({full_a, ovf_a} !== 8'h00) begin n_bad++; $display("FAIL rst_full_ovf: got %0h want 0", {full_a, ovf_a}); end
    n_cmp++; if ({infl_a, drop_a} !== 32'h0) begin n_bad++; $display("FAIL rst_cnt: got %0h want 0", {infl_a, drop_a}); end
    n_cmp++; if ({err_a, done_a} !== 2'b00) begin n_bad++; $display("FAIL rst_err_done: got %b want 00", {err_a, done_a}); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    req_in[0] = mk(16'd1); cyc(); req_in = '0;
    n_cmp++; if (drop_a !== 16'd1) begin n_bad++; $display("FAIL idle_drop: got %0d want 1", drop_a); end
    n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL idle_done: got %b want 0", done_a); end
    n_cmp++; if (ovf_a !== 4'b0000) begin n_bad++; $display("FAIL idle_ovf: got %b want 0000", ovf_a); end
  endtask

  task automatic test_fill();
    do_reset(); start_run();
    ready = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      req_in[2] = mk(16'(10 + i)); cyc();
      if (i == 2) begin
        n_cmp++; if (full_a[2] !== 1'b0) begin n_bad++; $display("FAIL fill_not_full3: got %b want 0", full_a[2]); end
      end
      if (i == 3) begin
        n_cmp++; if (full_a[2] !== 1'b1) begin n_bad++; $display("FAIL fill_full4: got %b want 1", full_a[2]); end
      end
    end
    req_in = '0;
    n_cmp++; if (drop_a !== 16'd2) begin n_bad++; $display("FAIL fill_drop: got %0d want 2", drop_a); end
    n_cmp++; if (ovf_a !== 4'b0100) begin n_bad++; $display("FAIL fill_ovf: got %b want 0100", ovf_a); end
    n_cmp++; if (out_a[2].valid !== 1'b1 || out_a[2].id !== 16'd10) begin n_bad++; $display("FAIL fill_hold: got v=%b id=%0d want v=1 id=10", out_a[2].valid, out_a[2].id); end
    ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (out_a[2].valid !== 1'b1 || out_a[2].id !== 16'(10 + i)) begin n_bad++; $display("FAIL fill_order%0d: got v=%b id=%0d want id=%0d", i, out_a[2].valid, out_a[2].id, 10 + i); end
      cyc();
    end
    n_cmp++; if (out_a[2].valid !== 1'b0 || full_a !== 4'b0000) begin n_bad++; $display("FAIL fill_empty: got v=%b full=%b want 0/0000", out_a[2].valid, full_a); end
    n_cmp++; if (infl_a !== 16'd4) begin n_bad++; $display("FAIL fill_infl: got %0d want 4", infl_a); end
  endtask

  task automatic test_pushpop();
    ready = 4'b1011;
    for (int i = 0; i < 4; i++) begin req_in[2] = mk(16'(20 + i)); cyc(); end
    req_in[2] = mk(16'd24); ready = 4'b1111; cyc(); req_in = '0;
    n_cmp++; if (full_a[2] !== 1'b1) begin n_bad++; $display("FAIL pp_full: got %b want 1", full_a[2]); end
    n_cmp++; if (drop_a !== 16'd2) begin n_bad++; $display("FAIL pp_drop: got %0d want 2", drop_a); end
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (out_a[2].id !== 16'(21 + i)) begin n_bad++; $display("FAIL pp_order%0d: got %0d want %0d", i, out_a[2].id, 21 + i); end
      cyc();
    end
    n_cmp++; if (infl_a !== 16'd9) begin n_bad++; $display("FAIL pp_infl: got %0d want 9", infl_a); end
  endtask

  task automatic test_bypass();
    do_reset(); start_run();
    ready = 4'b1111; req_in[0] = mk(16'd7); #1;
    n_cmp++; if (out_b[0].valid !== 1'b1 || out_b[0].id !== 16'd7) begin n_bad++; $display("FAIL byp_same: got v=%b id=%0d want v=1 id=7", out_b[0].valid, out_b[0].id); end
    n_cmp++; if (out_a[0].valid !== 1'b0) begin n_bad++; $display("FAIL nobyp_same: got %b want 0", out_a[0].valid); end
    cyc(); req_in = '0; #1;
    n_cmp++; if (infl_b !== 16'd1) begin n_bad++; $display("FAIL byp_infl: got %0d want 1", infl_b); end
    n_cmp++; if (out_b[0].valid !== 1'b0 || full_b[0] !== 1'b0) begin n_bad++; $display("FAIL byp_empty: got v=%b full=%b want 0/0", out_b[0].valid, full_b[0]); end
    ready[0] = 1'b0; req_in[0] = mk(16'd8); #1;
    n_cmp++; if (out_b[0].valid !== 1'b1 || out_b[0].id !== 16'd8) begin n_bad++; $display("FAIL byp_nrdy_offer: got v=%b id=%0d want v=1 id=8", out_b[0].valid, out_b[0].id); end
    cyc(); req_in = '0; ready[0] = 1'b1; #1;
    n_cmp++; if (out_b[0].valid !== 1'b1 || out_b[0].id !== 16'd8) begin n_bad++; $display("FAIL byp_kept: got v=%b id=%0d want v=1 id=8", out_b[0].valid, out_b[0].id); end
    cyc();
    n_cmp++; if (infl_b !== 16'd2 || drop_b !== 16'd0) begin n_bad++; $display("FAIL byp_infl2: got infl=%0d drop=%0d want 2/0", infl_b, drop_b); end
  endtask

  task automatic test_drain();
    do_reset(); start_run();
    ready = 4'b1101;
    for (int i = 0; i < 5; i++) begin req_in[1] = mk(16'(30 + i)); cyc(); end
    req_in = '0;
    n_cmp++; if (drop_a !== 16'd1 || ovf_a !== 4'b0010) begin n_bad++; $display("FAIL dr_ovf: got drop=%0d ovf=%b want 1/0010", drop_a, ovf_a); end
    ready = 4'b1111; repeat (4) cyc();
    n_cmp++; if (infl_a !== 16'd4) begin n_bad++; $display("FAIL dr_infl4: got %0d want 4", infl_a); end
    for (int k = 0; k < NE; k++) begin del[k].valid = 1'b1; del[k].id = 16'(30 + k); end
    cyc(); del = '0;
    n_cmp++; if (infl_a !== 16'd0 || err_a !== 1'b0) begin n_bad++; $display("FAIL dr_del4: got infl=%0d err=%b want 0/0", infl_a, err_a); end
    req_in[0] = mk(16'd40); req_in[1] = mk(16'd41); req_in[3] = mk(16'd43);
    cyc(); req_in = '0; cyc();
    n_cmp++; if (infl_a !== 16'd3) begin n_bad++; $display("FAIL dr_infl3: got %0d want 3", infl_a); end
    fin = 1'b1; cyc(); fin = 1'b0;
    del[0].valid = 1'b1; del[1].valid = 1'b1; cyc(); del = '0;
    n_cmp++; if (infl_a !== 16'd1) begin n_bad++; $display("FAIL dr_infl1: got %0d want 1", infl_a); end
    del[3].valid = 1'b1; cyc(); del = '0;
    n_cmp++; if (infl_a !== 16'd0 || done_a !== 1'b0) begin n_bad++; $display("FAIL dr_infl0: got infl=%0d done=%b want 0/0", infl_a, done_a); end
    cyc();
    n_cmp++; if (done_a !== 1'b1) begin n_bad++; $display("FAIL dr_done: got %b want 1", done_a); end
    del[0].valid = 1'b1; cyc(); del = '0;
    n_cmp++; if (err_a !== 1'b1 || infl_a !== 16'd0) begin n_bad++; $display("FAIL dr_err: got err=%b infl=%0d want 1/0", err_a, infl_a); end
  endtask

  task automatic test_restart();
    req_in[2] = mk(16'd50); cyc(); req_in = '0;
    n_cmp++; if (drop_a !== 16'd2 || ovf_a !== 4'b0010) begin n_bad++; $display("FAIL rs_pre: got drop=%0d ovf=%b want 2/0010", drop_a, ovf_a); end
    start_run(); #1;
    n_cmp++; if (drop_a !== 16'd0 || ovf_a !== 4'b0000) begin n_bad++; $display("FAIL rs_clear: got drop=%0d ovf=%b want 0/0000", drop_a, ovf_a); end
    n_cmp++; if (err_a !== 1'b1 || done_a !== 1'b0) begin n_bad++; $display("FAIL rs_err_done: got err=%b done=%b want 1/0", err_a, done_a); end
    ready = 4'b1111; req_in[0] = mk(16'd51); cyc(); req_in = '0; #1;
    n_cmp++; if (out_a[0].valid !== 1'b1 || out_a[0].id !== 16'd51 || drop_a !== 16'd0) begin n_bad++; $display("FAIL rs_run: got v=%b id=%0d drop=%0d want 1/51/0", out_a[0].valid, out_a[0].id, drop_a); end
    cyc();
    n_cmp++; if (infl_a !== 16'd1) begin n_bad++; $display("FAIL rs_infl: got %0d want 1", infl_a); end
  endtask

  task automatic test_reset_mid();
    ready = 4'b0111;
    req_in[3] = mk(16'd60); cyc(); req_in[3] = mk(16'd61); cyc(); req_in = '0;
    #2 rst_n = 1'b0; #1;
    n_cmp++; if (out_a !== '0 || full_a !== 4'b0000) begin n_bad++; $display("FAIL mid_out: got out=%0h full=%b want 0", out_a, full_a); end
    n_cmp++; if (infl_a !== 16'd0 || drop_a !== 16'd0 || infl_b !== 16'd0) begin n_bad++; $display("FAIL mid_cnt: got %0d/%0d/%0d want 0", infl_a, drop_a, infl_b); end
    n_cmp++; if ({err_a, done_a, ovf_a} !== 6'b0) begin n_bad++; $display("FAIL mid_flags: got %b want 0", {err_a, done_a, ovf_a}); end
    @(posedge clk); #1 rst_n = 1'b1; cyc();
    n_cmp++; if (out_a[3].valid !== 1'b0 || drop_a !== 16'd0) begin n_bad++; $display("FAIL mid_flush: got v=%b drop=%0d want 0/0", out_a[3].valid, drop_a); end
  endtask

  initial begin
    req_in = '0; ready = '0; del = '0;
    test_reset();
    test_fill();
    test_pushpop();
    test_bypass();
    test_drain();
    test_restart();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/synfull_inj_queue.md
# synfull_inj_queue

Per-endpoint injection queue between the SynFull trace front-end and the ProNoC network interfaces. It replaces the software re-enqueue path (requests refused by a busy NE are bounced back to the C model) with a hardware FIFO per endpoint. Each FIFO has optional same-cycle bypass, overflow accounting, an in-flight packet counter fed by deliveries, and a run/drain/done controller so the testbench knows when traffic has fully retired.

## Interface
Parameters:
- NE, from pronoc_pkg: number of endpoints / lanes.
- DEPTH, 4: entries per lane FIFO. Power of two, ≥2.
- BYPASS, 1: 1 means an empty FIFO with a ready NE forwards the input request combinationally.
- CNT_W, 16: width of the in-flight and drop counters.

Ports:
- clk_i  in  1  clock. All logic is on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  level; begins or restarts a run.
- end_i  in  1  pulse/level; trace source exhausted, enter drain.
- req_in_i  in  NE×req_t  requests from the trace source (.valid, .src, .dest, .id, .size).
- full_o  out  NE  lane FIFO full (backpressure hint).
- NE_ready_all_i  in  NE  injector ready per endpoint.
- req_out_o  out  NE×req_t  requests to ProNoC. .valid means the head is offered.
- del_all_i  in  NE×deliver_t  ejected packets (.valid, .id).
- inflight_o  out  CNT_W  packets injected but not yet delivered.
- drop_cnt_o  out  CNT_W  requests lost (overflow or arrival outside RUN).
- ovf_o  out  NE  sticky per-lane overflow flag.
- err_o  out  1  sticky: delivery seen while inflight==0.
- done_o  out  1  high in state DONE.

## Operation
- **FSM states:** IDLE, RUN, DRAIN, DONE. Reset state is IDLE.
  - IDLE→RUN when start_i=1.
  - RUN→DRAIN when end_i=1.
  - DRAIN→DONE when all FIFOs are empty, no push or pop is occurring this cycle, and inflight==0.
  - DONE→RUN when start_i=1. This clears drop_cnt_o and ovf_o but not err_o.
- **Push:** lane k pushes when req_in_i[k].valid, state==RUN, and the lane is not bypassing.
  - Push into a full FIFO is accepted only if a pop of lane k happens the same cycle.
  - Otherwise the request is discarded: drop_cnt +1 and ovf_o[k] is set.
- **Out-of-RUN arrivals:** a valid input in IDLE, DRAIN or DONE is discarded with drop_cnt +1; ovf_o is unaffected.
- **Offer:** req_out_o[k].valid = (FIFO non-empty) | (BYPASS & empty & in.valid & state==RUN).
  - Payload comes from the head, or from req_in_i[k] when bypassing.
  - Pop/inject happens when the offer is valid and NE_ready_all_i[k]=1.
  - The offer is held stable until injected.
- **Bypass:** if a bypass candidate occurs while NE_ready_all_i[k]=0, the request is pushed instead. It is never lost.
- **In-flight counter:**
  - inflight_next = inflight + popcount(injected) − popcount(del_all_i[*].valid).
  - It saturates at 2^CNT_W−1.
  - If the decrement would go below 0: result is clamped to 0 and err_o is set.
- **drop_cnt:** adds popcount(drops) per cycle and saturates.

## Timing
- **Reset values** (all outputs, asynchronous): req_out_o all fields 0, full_o=0, inflight_o=0, drop_cnt_o=0, ovf_o=0, err_o=0, done_o=0. All FIFO pointers are 0.
- **Latency:**
  - Non-bypass push at edge t: head is offered in cycle t+1.
  - Bypass: 0 cycles, same-cycle inject.
- **full_o** is registered and reflects occupancy after the last edge.
- **Counters** update on the edge following the inject/deliver cycle.
- **done_o** rises one cycle after the DRAIN completion condition holds.
- **Pointer width:** log2(DEPTH)+1 bits. Full = MSBs differ and the remaining bits are equal. Wrap-around is natural.
- **Simultaneous events:**
  - end_i and start_i together in RUN: end wins.
  - start_i in RUN or DRAIN is ignored.
  - A delivery and an injection in the same cycle net out before clamping.
- **rst_i low mid-run:** all queued requests are flushed without being counted as drops.

## Structure
- req_t and deliver_t come from dpi_int_pkg.
- Add to dpi_int_pkg: the FSM state enum inj_state_t and the function popcount_ne.
- Sub-module synfull_lane_fifo (parameters DEPTH and the req_t payload) provides push, pop, empty, full, head and count. It is instantiated NE times in a generate loop.

## Test plan
- Reset asserted mid-traffic → all outputs 0 on the same cycle. After release, the state is IDLE and a valid input produces drop_cnt=1.
- NE=4, DEPTH=4, BYPASS=0, lane 2 ready held low, 6 pushes → full_o[2]=1 after the 4th, drop_cnt=2, ovf_o[2]=1. Raising ready drains ids in order at 1 per cycle.
- BYPASS=1, empty lane 0, ready=1, id=7 → req_out_o[0].valid=1 with id=7 in the same cycle. Next edge: inflight=1, lane stays empty.
- Full lane with push and ready-pop in the same cycle → no drop, occupancy stays at 4.
- Inject 3 packets, send end_i, deliver 3 packets (2 in one cycle) → inflight 3→1→0, then done_o=1 one cycle later. An extra delivery afterwards → err_o=1 and inflight stays 0.
- DONE then start_i → state RUN, drop_cnt_o and ovf_o cleared, err_o still held.
